// File: rtl/skew_feeder_pkg.sv
// Shared defaults, FSM state encoding and lane element type for the skew feeder.
package skew_pkg;
  localparam int unsigned LANES      = 8;
  localparam int unsigned ELEM_W     = 8;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned WORD_W     = 64;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
  typedef logic [ELEM_W-1:0] elem_t;
endpackage

// File: rtl/skew_feeder_if.sv
// Stream handshake from the banked buffer into the skew feeder.
interface skew_feeder_if;
  import skew_pkg::*;
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/skew_feeder_sync_fifo.sv
// Small synchronous FIFO with registered occupancy; read data is the head entry.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/skew_feeder.sv
// Buffers stream words, frames a tile, and staircase-skews lanes for a systolic array.
// Optional bubble counter port enabled by SKEW_FEEDER_PERF_CNT_EN.
module skew_feeder #(
  parameter int unsigned LANES      = skew_pkg::LANES,
  parameter int unsigned ELEM_W     = skew_pkg::ELEM_W,
  parameter int unsigned FIFO_DEPTH = skew_pkg::FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  skew_feeder_if.slave            stream,
  input  logic                    start,
  input  logic [7:0]              tile_len,
  output logic [LANES*ELEM_W-1:0] out_data,
  output logic [LANES-1:0]        out_valid,
  output logic                    busy,
  output logic                    done
`ifdef SKEW_FEEDER_PERF_CNT_EN
  ,
  output logic [15:0]             bubble_cnt
`endif
);
  import skew_pkg::*;

  state_t            state_q, state_d;
  logic [7:0]        remaining_q, remaining_d;
  logic [7:0]        drain_q, drain_d;
  logic              pop, fifo_full, fifo_empty;
  logic [WORD_W-1:0] fifo_q, stage_in;

  assign stream.in_ready = rst && !fifo_full;

  sync_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (stream.in_valid && stream.in_ready),
    .push_data (stream.in_data),
    .pop       (pop),
    .pop_data  (fifo_q),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    drain_d     = drain_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        remaining_d = tile_len;
        state_d     = (tile_len == 8'd0) ? DONE : FEED;
      end
      FEED: if (!fifo_empty) begin
        pop         = 1'b1;
        remaining_d = remaining_q - 8'd1;
        if (remaining_q == 8'd1) begin
          drain_d = '0;
          state_d = (LANES > 1) ? DRAIN : DONE;
        end
      end
      DRAIN: begin
        if (drain_q == 8'(LANES - 2)) state_d = DONE;
        else                          drain_d = drain_q + 8'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      drain_q     <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      drain_q     <= drain_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign stage_in = pop ? fifo_q : '0;

  // Lane i owns stage 0 plus i delay registers; bubbles ride the same chain.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [i:0][ELEM_W-1:0] data_q;
    logic [i:0]             vld_q;

    if (i == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (!rst) begin
          data_q <= '0;
          vld_q  <= '0;
        end else begin
          data_q <= stage_in[i*ELEM_W +: ELEM_W];
          vld_q  <= pop;
        end
      end
    end else begin : g_chain
      always_ff @(posedge clk) begin
        if (!rst) begin
          data_q <= '0;
          vld_q  <= '0;
        end else begin
          data_q <= {data_q[i-1:0], stage_in[i*ELEM_W +: ELEM_W]};
          vld_q  <= {vld_q[i-1:0], pop};
        end
      end
    end

    assign out_data[i*ELEM_W +: ELEM_W] = data_q[i];
    assign out_valid[i]                 = vld_q[i];
  end

`ifdef SKEW_FEEDER_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst)                                       bubble_cnt <= '0;
    else if (state_q == IDLE && start)              bubble_cnt <= '0;
    else if (state_q == FEED && fifo_empty && bubble_cnt != '1)
                                                    bubble_cnt <= bubble_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_skew_feeder.sv
// Directed bench for skew_feeder: reset, tiles with/without bubbles, backpressure, edge cases.
module tb_skew_feeder;
  import skew_pkg::*;

  logic        clk, rst, start;
  logic [7:0]  tile_len;
  logic [63:0] out_data;
  logic [7:0]  out_valid;
  logic        busy, done;
`ifdef SKEW_FEEDER_PERF_CNT_EN
  logic [15:0] bubble_cnt;
`endif

  int errors = 0;
  int checks = 0;

  int pop_at    [5];
  int push_from [5];
  int push_at   [5];
  int nwords;
  int base;

  skew_feeder_if sif ();

  skew_feeder #(.LANES(8), .ELEM_W(8), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .stream    (sif),
    .start     (start),
    .tile_len  (tile_len),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
`ifdef SKEW_FEEDER_PERF_CNT_EN
    ,
    .bubble_cnt(bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] word_of(input int b, input int j);
    logic [63:0] w;
    elem_t e;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      e = elem_t'(b + 16 * j + i);
      w[i*8 +: 8] = e;
    end
    return w;
  endfunction

  task automatic push_word(input logic [63:0] d);
    sif.in_valid = 1'b1;
    sif.in_data  = d;
    tick();
    sif.in_valid = 1'b0;
  endtask

  // Entered in cycle t0; checks cycles t0+1 .. t0+done_k+1.
  task automatic run_tile(input string name, input int len, input int done_k, input int ign_k);
    logic [7:0]  exp_v;
    logic [63:0] exp_d;
    start    = 1'b1;
    tile_len = 8'(len);
    for (int k = 1; k <= done_k + 1; k++) begin
      tick();
      start    = 1'b0;
      tile_len = 8'hFF;
      exp_v = '0;
      exp_d = '0;
      for (int j = 0; j < nwords; j++)
        for (int i = 0; i < 8; i++)
          if (pop_at[j] + 1 + i == k) begin
            exp_v[i] = 1'b1;
            exp_d[i*8 +: 8] = 8'(base + 16 * j + i);
          end
      chk($sformatf("%s k%0d out_valid", name, k), 64'(out_valid), 64'(exp_v));
      chk($sformatf("%s k%0d out_data", name, k), out_data, exp_d);
      chk($sformatf("%s k%0d busy", name, k), 64'(busy), 64'(k <= done_k));
      chk($sformatf("%s k%0d done", name, k), 64'(done), 64'(k == done_k));
      sif.in_valid = 1'b0;
      for (int j = 0; j < nwords; j++)
        if (k >= push_from[j] && k <= push_at[j]) begin
          sif.in_valid = 1'b1;
          sif.in_data  = word_of(base, j);
        end
      if (k == ign_k) begin
        start    = 1'b1;
        tile_len = 8'd9;
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    tile_len = '0;
    sif.in_valid = 1'b1;
    sif.in_data  = 64'hDEAD_BEEF_0000_0001;

    // reset held with traffic present
    tick(); tick(); tick();
    chk("rst in_ready", 64'(sif.in_ready), 64'd0);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    rst = 1'b1;
    sif.in_valid = 1'b0;
    tick();
    chk("rel in_ready", 64'(sif.in_ready), 64'd1);
    chk("rel out_valid", 64'(out_valid), 64'd0);
    chk("rel out_data", out_data, 64'd0);
    chk("rel busy", 64'(busy), 64'd0);

    // single word, preloaded
    base = 1; nwords = 1;
    pop_at[0] = 1; push_from[0] = -1; push_at[0] = -1;
    push_word(64'h0807060504030201);
    run_tile("single", 1, 9, -1);

    // four back-to-back words, start during FEED ignored
    base = 8'h10; nwords = 4;
    for (int j = 0; j < 4; j++) begin
      pop_at[j] = j + 1; push_from[j] = -1; push_at[j] = -1;
      chk($sformatf("fill%0d in_ready", j), 64'(sif.in_ready), 64'd1);
      push_word(word_of(base, j));
    end
    chk("full in_ready", 64'(sif.in_ready), 64'd0);
    run_tile("b2b", 4, 12, 2);

    // starved FIFO: second word two cycles late
    base = 8'h50; nwords = 3;
    pop_at[0] = 1; push_from[0] = -1; push_at[0] = -1;
    pop_at[1] = 4; push_from[1] = 3;  push_at[1] = 3;
    pop_at[2] = 5; push_from[2] = 4;  push_at[2] = 4;
    push_word(word_of(base, 0));
    run_tile("starve", 3, 13, -1);
`ifdef SKEW_FEEDER_PERF_CNT_EN
    chk("starve bubble_cnt", 64'(bubble_cnt), 64'd2);
`endif

    // backpressure: fifth word held until a pop frees space
    base = 8'h80; nwords = 5;
    for (int j = 0; j < 4; j++) begin
      pop_at[j] = j + 1; push_from[j] = -1; push_at[j] = -1;
      push_word(word_of(base, j));
    end
    pop_at[4] = 5; push_from[4] = 0; push_at[4] = 2;
    chk("bp full", 64'(sif.in_ready), 64'd0);
    sif.in_valid = 1'b1;
    sif.in_data  = word_of(base, 4);
    tick();
    chk("bp held", 64'(sif.in_ready), 64'd0);
    run_tile("bp", 5, 13, -1);

    // zero-length tile
    start = 1'b1;
    tile_len = 8'd0;
    tick();
    start = 1'b0;
    chk("len0 done", 64'(done), 64'd1);
    chk("len0 busy", 64'(busy), 64'd1);
    chk("len0 out_valid", 64'(out_valid), 64'd0);
`ifdef SKEW_FEEDER_PERF_CNT_EN
    chk("len0 bubble_cnt", 64'(bubble_cnt), 64'd0);
`endif
    tick();
    chk("len0 after done", 64'(done), 64'd0);
    chk("len0 after busy", 64'(busy), 64'd0);
    chk("len0 after out_valid", 64'(out_valid), 64'd0);

    // reset in the middle of FEED
    push_word(word_of(8'hA0, 0));
    start = 1'b1;
    tile_len = 8'd3;
    tick();
    start = 1'b0;
    tick();
    chk("midrst lane0 valid", 64'(out_valid), 64'h01);
    chk("midrst lane0 data", out_data, 64'h00000000000000A0);
    rst = 1'b0;
    tick();
    chk("midrst out_valid", 64'(out_valid), 64'd0);
    chk("midrst out_data", out_data, 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    chk("midrst in_ready", 64'(sif.in_ready), 64'd0);
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("post k%0d done", k), 64'(done), 64'd0);
      chk($sformatf("post k%0d out_valid", k), 64'(out_valid), 64'd0);
    end
    chk("post busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/skew_feeder.md
# skew_feeder

Downstream consumer of the banked buffer's 64-bit stream. Buffers incoming stream words in a small FIFO, splits each word into per-row elements, and applies the diagonal (staircase) skew the systolic array needs so that row i receives its element i cycles after row 0. A start/tile_len command frames one tile; the block then feeds, drains the skew pipeline, and pulses done.

## Interface
- LANES, 8, number of array rows fed; LANES*ELEM_W must equal 64
- ELEM_W, 8, element width in bits
- FIFO_DEPTH, 4, input FIFO entries (power of two, ≥2)
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset
- in_data  input  64  stream word from banked buffer; lane i = bits [i*ELEM_W +: ELEM_W]
- in_valid  input  1  in_data valid
- in_ready  output  1  FIFO can accept a word
- start  input  1  begin a tile (sampled only in IDLE)
- tile_len  input  8  words in the tile, captured on start
- out_data  output  LANES*ELEM_W  skewed lane elements to array rows
- out_valid  output  LANES  per-lane element valid
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse at end of tile

## Operation
- Push: in_valid && in_ready writes in_data into FIFO, in any state (prefetch allowed).
- FSM: IDLE -> FEED on start (tile_len != 0); remaining = tile_len. IDLE -> DONE on start with tile_len == 0.
- FEED: each cycle, if FIFO non-empty, pop one word into skew stage 0 with valid=1, remaining--; if empty, insert bubble (zeros, valid=0). After last pop -> DRAIN.
- DRAIN: shift zeros/valid=0 for LANES-1 cycles, then -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- Skew: lane i carries a chain of i registers after stage 0; bubbles propagate diagonally like data, so array alignment is preserved.
- start while busy: ignored. tile_len captured once; later changes ignored.

## Timing
- Reset (rst=0 at edge): FIFO emptied, skew regs zero, state IDLE. During reset in_ready=0; all other outputs 0. First cycle after release: in_ready=1, out_*=0, busy=0, done=0.
- in_ready = !full (registered count); no push when full even if a pop occurs same cycle.
- No FIFO bypass: word pushed in cycle t is poppable earliest in t+1.
- Word popped in cycle t: lane 0 out at t+1, lane i out at t+1+i.
- Tile with no bubbles: start at t0 -> FEED t0+1 … t0+tile_len, DRAIN LANES-1 cycles, done at t0+tile_len+LANES.
- Last lane element of last word appears in the same cycle done pulses.
- Reset mid-tile: discards FIFO contents and in-flight skew data; no done pulse.

## Configuration
- SKEW_FEEDER_PERF_CNT_EN defined: extra output bubble_cnt (16 bits), cleared on reset and on start, increments each FEED bubble cycle, saturates at 16'hFFFF.
- Undefined: port and counter absent; behaviour otherwise identical.

## Structure
- Package skew_pkg: LANES, ELEM_W defaults, state enum typedef (IDLE, FEED, DRAIN, DONE), lane-element typedef.
- One sub-module: sync_fifo (parameterised width/depth, push/pop, full/empty, synchronous active-low reset).

## Test plan
- Reset: hold rst=0 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, busy=0; after release in_ready=1, FIFO empty.
- Single word 64'h0807060504030201, tile_len=1, preloaded -> lane i shows byte i+1 with out_valid[i]=1 at cycle t0+2+i; done at t0+1+8.
- Back-to-back 4 words, tile_len=4 -> each lane gets 4 consecutive valid elements, diagonal shift of 1 cycle per lane, done at t0+12.
- Starved FIFO: tile_len=3, second word arrives 2 cycles late -> 2-cycle bubble diagonal in all lanes, out_valid low during bubble, bubble_cnt=2 (with SKEW_FEEDER_PERF_CNT_EN).
- Backpressure: push 5 words with FIFO_DEPTH=4, no start -> in_ready drops after 4th; 5th held until start pops one.
- Edge cases: start with tile_len=0 -> done next cycle, no valid output; start during FEED ignored; rst=0 mid-FEED -> outputs zero next cycle, no done.
